// File: rtl/iq_axis_source_pkg.sv
// Shared FSM state encoding and read-ahead limit for the IQ AXI-stream source.
package iq_axis_source_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  // FIFO depth; RAM reads in flight plus buffered beats never exceed this
  localparam int RD_SLOTS = 2;

endpackage

// File: rtl/iq_skid_fifo.sv
// Two-entry valid/ready buffer; push-to-out 1 cycle, head holds while out_rdy is low.
// Producer must watch level and never push into a full buffer.
module iq_skid_fifo #(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_dat,
  input  logic             out_rdy,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       level
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;
  logic [1:0]       cnt;
  logic             pop;

  assign pop     = out_vld & out_rdy;
  assign out_vld = (cnt != 2'd0);
  assign out_dat = head;
  assign level   = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      cnt <= 2'd0;
    end else begin
      case ({in_vld, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= in_dat;
          else             tail <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            head <= in_dat;
          end else begin
            head <= tail;
            tail <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iq_axis_source.sv
// Sample RAM loaded over a write port, replayed as an AXI-stream burst; first beat 2 cycles after start.
// IQ_SOURCE_LOOP_EN: bursts repeat back-to-back until stop, done pulses once at the end.
module iq_axis_source
  import iq_axis_source_pkg::*;
#(
  parameter int I_BITS     = 16,
  parameter int Q_BITS     = 16,
  parameter int LENGTH     = 1024,
  parameter int INDEX_BITS = 10,
  parameter int TDATA_BITS = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       m_axi_wvalid,
  input  logic [INDEX_BITS-1:0]      m_axi_waddr,
  input  logic [I_BITS+Q_BITS-1:0]   m_axi_wdata,
  output logic                       s_axi_wready,
  input  logic                       start,
  input  logic                       stop,
  input  logic [INDEX_BITS:0]        burst_len,
  output logic                       m_axis_tvalid,
  output logic [TDATA_BITS-1:0]      m_axis_tdata,
  output logic                       m_axis_tlast,
  input  logic                       s_axis_tready,
  output logic                       busy,
  output logic                       done
);

  localparam int                  IQ_BITS = I_BITS + Q_BITS;
  localparam logic [INDEX_BITS:0] LEN_MAX = (INDEX_BITS+1)'(LENGTH);
  localparam logic [INDEX_BITS:0] LEN_ONE = (INDEX_BITS+1)'(1);

  state_t              state;
  state_t              state_nxt;
  logic [IQ_BITS-1:0]  mem [LENGTH];
  logic [IQ_BITS-1:0]  rd_dat;
  logic                rd_vld;
  logic                rd_last;
  logic [INDEX_BITS:0] rd_cnt;
  logic [INDEX_BITS:0] last_idx;
  logic [INDEX_BITS:0] len_eff;
  logic                stop_q;
  logic                issue;
  logic                issue_ok;
  logic                hs;
  logic                burst_end;
  logic                fifo_vld;
  logic [IQ_BITS:0]    fifo_dat;
  logic [1:0]          fifo_lvl;

  assign len_eff = (burst_len == '0 || burst_len > LEN_MAX) ? LEN_MAX : burst_len;
  assign hs      = m_axis_tvalid & s_axis_tready;

`ifdef IQ_SOURCE_LOOP_EN
  assign burst_end = hs & m_axis_tlast & (stop_q | stop);
  assign issue_ok  = 1'b1;
`else
  // stop is still latched in single-burst builds but cannot change the outcome
  logic unused_stop;
  assign unused_stop = stop_q;
  assign burst_end   = hs & m_axis_tlast;
  assign issue_ok    = (rd_cnt <= last_idx);
`endif

  // Counting the beat leaving this cycle keeps the pipe full at tready=1
  assign issue = (state == STREAM) & issue_ok &
                 (({1'b0, fifo_lvl} + {2'b0, rd_vld}) < (3'(RD_SLOTS) + {2'b0, hs}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = STREAM;
      STREAM:  if (burst_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_axi_wready = (state == IDLE);
    busy         = (state != IDLE);
    done         = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt   <= '0;
      last_idx <= '0;
      stop_q   <= 1'b0;
      rd_vld   <= 1'b0;
      rd_last  <= 1'b0;
    end else begin
      rd_vld <= issue;
      if (state == IDLE) begin
        stop_q <= 1'b0;
        if (start) begin
          rd_cnt   <= '0;
          last_idx <= len_eff - LEN_ONE;
        end
      end else if (stop) begin
        stop_q <= 1'b1;
      end
      if (issue) begin
        rd_last <= (rd_cnt == last_idx);
`ifdef IQ_SOURCE_LOOP_EN
        rd_cnt  <= (rd_cnt == last_idx) ? '0 : rd_cnt + LEN_ONE;
`else
        rd_cnt  <= rd_cnt + LEN_ONE;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (m_axi_wvalid && s_axi_wready) mem[m_axi_waddr] <= m_axi_wdata;
    if (issue) rd_dat <= mem[rd_cnt[INDEX_BITS-1:0]];
  end

  // Leaving STREAM discards any read-ahead from a burst that will not be sent
  iq_skid_fifo #(.WIDTH(IQ_BITS + 1)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (state != STREAM),
    .in_vld  (rd_vld & (state == STREAM)),
    .in_dat  ({rd_last, rd_dat}),
    .out_rdy (s_axis_tready & (state == STREAM)),
    .out_vld (fifo_vld),
    .out_dat (fifo_dat),
    .level   (fifo_lvl)
  );

  assign m_axis_tvalid = fifo_vld & (state == STREAM);
  assign m_axis_tlast  = m_axis_tvalid & fifo_dat[IQ_BITS];
  assign m_axis_tdata  = m_axis_tvalid ? TDATA_BITS'(fifo_dat[IQ_BITS-1:0]) : '0;

endmodule

// File: tb/tb_iq_axis_source.sv
// Bench for iq_axis_source: RAM model plus expected beat list per burst, table of burst lengths,
// randomized RAM contents and tready, hand sequences for stall, write-drop, stop and reset.
module tb_iq_axis_source;

  localparam int I_BITS     = 16;
  localparam int Q_BITS     = 16;
  localparam int LENGTH     = 1024;
  localparam int INDEX_BITS = 10;
  localparam int TDATA_BITS = 32;
  localparam int IQ_BITS    = I_BITS + Q_BITS;
`ifdef IQ_SOURCE_LOOP_EN
  localparam int STOP_DEF = 0;
`else
  localparam int STOP_DEF = -1;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  m_axi_wvalid = 1'b0;
  logic [INDEX_BITS-1:0] m_axi_waddr = '0;
  logic [IQ_BITS-1:0]    m_axi_wdata = '0;
  logic                  s_axi_wready;
  logic                  start = 1'b0;
  logic                  stop = 1'b0;
  logic [INDEX_BITS:0]   burst_len = '0;
  logic                  m_axis_tvalid;
  logic [TDATA_BITS-1:0] m_axis_tdata;
  logic                  m_axis_tlast;
  logic                  s_axis_tready = 1'b0;
  logic                  busy;
  logic                  done;

  iq_axis_source #(
    .I_BITS(I_BITS), .Q_BITS(Q_BITS), .LENGTH(LENGTH),
    .INDEX_BITS(INDEX_BITS), .TDATA_BITS(TDATA_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_waddr(m_axi_waddr), .m_axi_wdata(m_axi_wdata),
    .s_axi_wready(s_axi_wready),
    .start(start), .stop(stop), .burst_len(burst_len),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [IQ_BITS-1:0]    ref_mem [LENGTH];
  logic [TDATA_BITS:0]   obs_q [$];
  logic [TDATA_BITS:0]   beat_prev;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_hs_cyc = -1;
  int last_hs_cyc = -1;
  int rdy_pct = 100;
  bit rdy_toggle = 1'b0;
  bit stall_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_toggle) s_axis_tready = ~s_axis_tready;
    else            s_axis_tready = ($urandom_range(0, 99) < rdy_pct);
  end

  // Stream monitor: records handshaken beats and enforces hold-while-stalled
  initial forever begin
    @(negedge clk);
    if (stall_prev)
      check("hold while stalled", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, beat_prev});
    if (m_axis_tvalid && s_axis_tready) begin
      obs_q.push_back({m_axis_tlast, m_axis_tdata});
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      if (m_axis_tlast) last_hs_cyc = cyc;
    end
    stall_prev = m_axis_tvalid && !s_axis_tready && rst_n;
    beat_prev  = {m_axis_tlast, m_axis_tdata};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic wr(input int a, input logic [IQ_BITS-1:0] d, input bit chk);
    @(negedge clk);
    if (chk) check("wready in IDLE", s_axi_wready, 1);
    m_axi_wvalid = 1'b1;
    m_axi_waddr  = a[INDEX_BITS-1:0];
    m_axi_wdata  = d;
    ref_mem[a]   = d;
    @(posedge clk);
    #1 m_axi_wvalid = 1'b0;
  endtask

  // mode 0: plain, 1: write attempt during STREAM, 2: write issued together with start
  task automatic run_burst(input string name, input logic [INDEX_BITS:0] blen, input int len,
                           input int n_bursts, input int stop_after, input int mode);
    int total;
    int budget;
    int first_bad;
    logic [TDATA_BITS:0] exp_beat;
    total     = len * n_bursts;
    first_bad = -1;
    obs_q.delete();
    done_cnt = 0;
    first_hs_cyc = -1;
    last_hs_cyc = -1;
    @(negedge clk);
    start     = 1'b1;
    burst_len = blen;
    if (stop_after == 0) stop = 1'b1;
    if (mode == 2) begin
      m_axi_wvalid = 1'b1;
      m_axi_waddr  = '0;
      m_axi_wdata  = 32'h0BAD_F00D;
      ref_mem[0]   = 32'h0BAD_F00D;
    end
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    m_axi_wvalid = 1'b0;
    check({name, " busy"}, busy, 1);
    check({name, " tvalid before k+1"}, m_axis_tvalid, 0);
    @(negedge clk);
    check({name, " tvalid before k+2"}, m_axis_tvalid, 0);
    if (mode == 1) begin
      m_axi_wvalid = 1'b1;
      m_axi_waddr  = 2;
      m_axi_wdata  = 32'hDEAD_BEEF;
      check({name, " wready in STREAM"}, s_axi_wready, 0);
    end
    @(negedge clk);
    m_axi_wvalid = 1'b0;
    check({name, " tvalid after k+2"}, m_axis_tvalid, 1);
    if (stop_after > 0) begin
      for (int c = 0; c < 2000 && obs_q.size() < stop_after; c++) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
    end
    budget = total * 30 + 100;
    for (int c = 0; c < budget && done_cnt == 0; c++) @(negedge clk);
    stop = 1'b0;
    repeat (4) @(negedge clk);
    check({name, " done pulses"}, done_cnt, 1);
    check({name, " done one cycle after tlast"}, done_cyc - last_hs_cyc, 1);
    check({name, " beat count"}, obs_q.size(), total);
    for (int i = 0; i < obs_q.size() && i < total; i++) begin
      exp_beat = {((i % len) == len - 1), TDATA_BITS'(ref_mem[i % len])};
      if (first_bad < 0 && obs_q[i] !== exp_beat) begin
        first_bad = i;
        check({name, " beat value"}, obs_q[i], exp_beat);
      end
    end
    check({name, " first bad beat index"}, first_bad, -1);
    if (rdy_pct == 100 && !rdy_toggle)
      check({name, " back-to-back beats"}, last_hs_cyc - first_hs_cyc, total - 1);
    check({name, " idle after {busy,tvalid,wready}"}, {busy, m_axis_tvalid, s_axi_wready}, 3'b001);
  endtask

  typedef struct {
    logic [INDEX_BITS:0] blen;
    int                  len;
    int                  pct;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{11'd0,    LENGTH, 100};
    vecs[1] = '{11'd5,    5,      60};
    vecs[2] = '{11'd2047, LENGTH, 80};
    vecs[3] = '{11'd1,    1,      40};
    vecs[4] = '{11'd17,   17,     100};
    vecs[5] = '{11'd1024, LENGTH, 100};

    #12;
    check("reset tvalid", m_axis_tvalid, 0);
    check("reset tlast", m_axis_tlast, 0);
    check("reset tdata", m_axis_tdata, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset wready", s_axi_wready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    rdy_pct = 100;
    wr(0, {16'd1, 16'd2}, 1);
    wr(1, {16'd3, 16'd4}, 1);
    wr(2, {16'd5, 16'd6}, 1);
    wr(3, {16'd7, 16'd8}, 1);
    run_burst("t1 basic", 4, 4, 1, STOP_DEF, 0);

    rdy_toggle = 1'b1;
    run_burst("t2 toggle ready", 4, 4, 1, STOP_DEF, 0);
    rdy_toggle = 1'b0;

    run_burst("t3 write in stream", 4, 4, 1, STOP_DEF, 1);
    run_burst("t3 replay", 4, 4, 1, STOP_DEF, 0);
    run_burst("write with start", 4, 4, 1, STOP_DEF, 2);

    for (int a = 0; a < LENGTH; a++) wr(a, IQ_BITS'($urandom), 0);
    for (int i = 0; i < 6; i++) begin
      rdy_pct = vecs[i].pct;
      run_burst($sformatf("vec%0d", i), vecs[i].blen, vecs[i].len, 1, STOP_DEF, 0);
    end

    rdy_pct = 100;
`ifdef IQ_SOURCE_LOOP_EN
    run_burst("t5 loop stop", 3, 3, 2, 4, 0);
`else
    run_burst("stop no effect", 3, 3, 1, 1, 0);
`endif

    @(negedge clk);
    start = 1'b1;
    burst_len = 8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("pre-reset tvalid", m_axis_tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("mid reset tvalid", m_axis_tvalid, 0);
    check("mid reset busy", busy, 0);
    check("mid reset tdata/tlast", {m_axis_tlast, m_axis_tdata}, 0);
    check("mid reset wready", s_axi_wready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < 4; a++) wr(a, IQ_BITS'($urandom), 0);
    run_burst("t6 replay after reset", 4, 4, 1, STOP_DEF, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
